// File: rtl/rv32i_alu_decode_stage.sv
// RV32I decode stage: registered valid/ready pipeline stage with a one-entry skid buffer.
// Decodes a fetched instruction into the ALU control bundle consumed by execute.
// Operand indices that an instruction does not read are driven as 0. The pc passes through
// unchanged, including for illegal encodings.
module rv32i_alu_decode_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic [1:0]       out_a_sel,
  output logic             out_b_imm,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_is_branch,
  output logic             out_br_inv,
  output logic             out_illegal,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] AluAdd  = 4'h0;
  localparam logic [3:0] AluSub  = 4'h1;
  localparam logic [3:0] AluAnd  = 4'h2;
  localparam logic [3:0] AluOr   = 4'h3;
  localparam logic [3:0] AluXor  = 4'h4;
  localparam logic [3:0] AluSll  = 4'h5;
  localparam logic [3:0] AluSrl  = 4'h6;
  localparam logic [3:0] AluSra  = 4'h7;
  localparam logic [3:0] AluEq   = 4'h8;
  localparam logic [3:0] AluLtu  = 4'h9;
  localparam logic [3:0] AluLt   = 4'hA;
  localparam logic [3:0] AluGeu  = 4'hB;
  localparam logic [3:0] AluGe   = 4'hC;
  localparam logic [3:0] AluJalr = 4'hD;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [1:0] ASelRs1  = 2'd0;
  localparam logic [1:0] ASelPc   = 2'd1;
  localparam logic [1:0] ASelZero = 2'd2;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_branch;
    logic        br_inv;
    logic        illegal;
    logic [31:0] pc;
  } bundle_t;

  // ALU code for the funct7=0 register/immediate arithmetic group
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = AluAdd;
      3'b001:  code = AluSll;
      3'b010:  code = AluLt;
      3'b011:  code = AluLtu;
      3'b100:  code = AluXor;
      3'b101:  code = AluSrl;
      3'b110:  code = AluOr;
      default: code = AluAnd;
    endcase
    return code;
  endfunction

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  bundle_t dec;
  logic    bad;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OpcOp: begin
        dec.rd  = f_rd;
        dec.rs1 = f_rs1;
        dec.rs2 = f_rs2;
        if (funct7 == F7Zero) begin
          dec.alu_ctrl = alu_base(funct3);
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          dec.alu_ctrl = AluSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          dec.alu_ctrl = AluSra;
        end else begin
          bad = 1'b1;
        end
      end
      OpcOpImm: begin
        dec.rd    = f_rd;
        dec.rs1   = f_rs1;
        dec.b_imm = 1'b1;
        if (funct3 == 3'b001) begin
          dec.alu_ctrl = AluSll;
          dec.imm      = imm_sh;
          bad          = (funct7 != F7Zero);
        end else if (funct3 == 3'b101) begin
          dec.alu_ctrl = (funct7 == F7Alt) ? AluSra : AluSrl;
          dec.imm      = imm_sh;
          bad          = (funct7 != F7Zero) && (funct7 != F7Alt);
        end else begin
          dec.alu_ctrl = alu_base(funct3);
          dec.imm      = imm_i;
        end
      end
      OpcLui: begin
        dec.rd    = f_rd;
        dec.a_sel = ASelZero;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OpcAuipc: begin
        dec.rd    = f_rd;
        dec.a_sel = ASelPc;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OpcJal: begin
        dec.rd    = f_rd;
        dec.a_sel = ASelPc;
        dec.b_imm = 1'b1;
        dec.imm   = imm_j;
      end
      OpcJalr: begin
        dec.rd       = f_rd;
        dec.rs1      = f_rs1;
        dec.alu_ctrl = AluJalr;
        dec.b_imm    = 1'b1;
        dec.imm      = imm_i;
        bad          = (funct3 != 3'b000);
      end
      OpcLoad: begin
        dec.rd    = f_rd;
        dec.rs1   = f_rs1;
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
      end
      OpcStore: begin
        dec.rs1   = f_rs1;
        dec.rs2   = f_rs2;
        dec.b_imm = 1'b1;
        dec.imm   = imm_s;
      end
      OpcBranch: begin
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000: dec.alu_ctrl = AluEq;
          3'b001: begin
            dec.alu_ctrl = AluEq;
            dec.br_inv   = 1'b1;
          end
          3'b100: dec.alu_ctrl = AluLt;
          3'b101: dec.alu_ctrl = AluGe;
          3'b110: dec.alu_ctrl = AluLtu;
          3'b111: dec.alu_ctrl = AluGeu;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = in_pc;
  end

  bundle_t          o_q, o_d, s_q, s_d;
  logic             o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  // Ready depends only on skid occupancy, never on out_ready
  assign in_ready = ~s_valid_q & ~reset;
  assign accept   = in_valid & in_ready;
  assign drain    = o_valid_q & out_ready;

  // Next-state for output register, skid register and illegal counter
  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    if (s_valid_q) begin
      if (drain) begin
        o_d       = s_q;
        s_d       = '0;
        s_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!o_valid_q || drain) begin
        o_d       = dec;
        o_valid_d = 1'b1;
      end else begin
        s_d       = dec;
        s_valid_d = 1'b1;
      end
    end else if (drain) begin
      o_valid_d = 1'b0;
    end
    if (drain && o_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with synchronous reset discarding any in-flight entries
  always_ff @(posedge clk) begin
    if (reset) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid     = o_valid_q;
  assign out_alu_ctrl  = o_q.alu_ctrl;
  assign out_a_sel     = o_q.a_sel;
  assign out_b_imm     = o_q.b_imm;
  assign out_imm       = o_q.imm;
  assign out_rd        = o_q.rd;
  assign out_rs1       = o_q.rs1;
  assign out_rs2       = o_q.rs2;
  assign out_is_branch = o_q.is_branch;
  assign out_br_inv    = o_q.br_inv;
  assign out_illegal   = o_q.illegal;
  assign out_pc        = o_q.pc;
  assign illegal_cnt   = cnt_q;

endmodule
